// File: rtl/ccu_snoop_port_arbiter_pkg.sv
// Shared snoop-channel types for the CCU snoop port arbiter.
package ccu_snoop_port_arbiter_pkg;

    localparam int AcAddrW = 16;
    localparam int CdDataW = 32;
    localparam int DomainW = 4;

    // Snoop responses come back in AC issue order, which is what makes owner FIFOs sufficient.
    localparam bit ORDERED_RESP = 1'b1;

    typedef logic [DomainW-1:0] domain_mask_t;

    typedef struct packed {
        logic [AcAddrW-1:0] addr;
        logic [3:0]         snoop;
        logic [2:0]         prot;
    } ac_chan_t;

    typedef struct packed {
        logic was_unique;
        logic is_shared;
        logic pass_dirty;
        logic error;
        logic data_transfer;
    } cr_resp_t;

    typedef struct packed {
        logic [CdDataW-1:0] data;
        logic               last;
    } cd_chan_t;

    typedef struct packed {
        logic     ac_valid;
        ac_chan_t ac;
        logic     cr_ready;
        logic     cd_ready;
    } mst_snoop_req_t;

    typedef struct packed {
        logic     ac_ready;
        logic     cr_valid;
        cr_resp_t cr_resp;
        logic     cd_valid;
        cd_chan_t cd;
    } mst_snoop_resp_t;

endpackage

// File: rtl/ccu_snoop_port_arbiter_rr_arb.sv
// AC grant selection with lock-until-handshake; round-robin by default.
// Define CCU_SNOOP_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer).
module ccu_snoop_port_arbiter_rr_arb #(
    parameter int NumReq = 2,
    parameter int IdxW   = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NumReq-1:0] i_req,
    input  logic              i_stall,
    input  logic              i_hs,
    output logic [IdxW-1:0]   o_gnt_idx,
    output logic              o_gnt_vld
);

    logic            r_lock_vld;
    logic [IdxW-1:0] r_lock_idx;
    logic [IdxW-1:0] w_sel_idx;
    logic            w_sel_vld;

`ifdef CCU_SNOOP_ARB_FIXED_PRIO_EN
    always_comb begin
        w_sel_idx = '0;
        w_sel_vld = 1'b0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_sel_idx = IdxW'(i);
                w_sel_vld = 1'b1;
            end
        end
    end
`else
    logic [IdxW-1:0] r_ptr;
    logic [IdxW-1:0] w_k;

    // Operand is always below 2*NumReq, so a single conditional subtract wraps it.
    function automatic logic [IdxW-1:0] f_wrap(input logic [IdxW:0] v);
        return (v >= (IdxW+1)'(NumReq)) ? IdxW'(v - (IdxW+1)'(NumReq)) : IdxW'(v);
    endfunction

    // Walk from the far end so the candidate closest to the pointer is written last.
    always_comb begin
        w_sel_idx = '0;
        w_sel_vld = 1'b0;
        w_k       = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            w_k = f_wrap({1'b0, r_ptr} + (IdxW+1)'(i));
            if (i_req[w_k]) begin
                w_sel_idx = w_k;
                w_sel_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_hs) begin
            r_ptr <= f_wrap({1'b0, o_gnt_idx} + (IdxW+1)'(1));
        end
    end
`endif

    assign o_gnt_idx = r_lock_vld ? r_lock_idx : w_sel_idx;
    assign o_gnt_vld = r_lock_vld ? i_req[r_lock_idx] : w_sel_vld;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lock_vld <= 1'b0;
            r_lock_idx <= '0;
        end else if (i_hs) begin
            r_lock_vld <= 1'b0;
        end else if (i_stall) begin
            r_lock_vld <= 1'b1;
            r_lock_idx <= o_gnt_idx;
        end
    end

endmodule

// File: rtl/ccu_snoop_port_arbiter.sv
// Shares one AC/CR/CD snoop port between NumReq controllers; CR/CD steered back via owner FIFOs.
// Define CCU_SNOOP_ARB_FIXED_PRIO_EN for fixed-priority AC arbitration instead of round-robin.
module ccu_snoop_port_arbiter
    import ccu_snoop_port_arbiter_pkg::*;
#(
    parameter int NumReq         = 2,
    parameter int MaxOutstanding = 4,
    parameter int MaxCdPending   = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  mst_snoop_req_t  [NumReq-1:0]  slv_snoop_req_i,
    output mst_snoop_resp_t [NumReq-1:0]  slv_snoop_resp_o,
    input  domain_mask_t    [NumReq-1:0]  slv_domain_mask_i,
    input  logic            [NumReq-1:0]  slv_excl_load_i,
    input  logic            [NumReq-1:0]  slv_excl_store_i,
    output logic            [NumReq-1:0]  slv_excl_resp_o,
    output mst_snoop_req_t                mst_snoop_req_o,
    input  mst_snoop_resp_t               mst_snoop_resp_i,
    output domain_mask_t                  mst_domain_mask_o,
    output logic                          mst_excl_load_o,
    output logic                          mst_excl_store_o,
    input  logic                          mst_excl_resp_i
);

    localparam int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int CrPtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CrCntW = $clog2(MaxOutstanding + 1);
    localparam int CdPtrW = (MaxCdPending > 1) ? $clog2(MaxCdPending) : 1;
    localparam int CdCntW = $clog2(MaxCdPending + 1);

    typedef logic [IdxW-1:0] idx_t;

    logic [NumReq-1:0] w_ac_req;
    idx_t              w_gnt_idx;
    logic              w_gnt_vld;
    logic              w_mst_ac_vld;
    logic              w_ac_hs;
    logic              w_ac_stall;

    idx_t              r_cr_mem [MaxOutstanding];
    logic [CrPtrW-1:0] r_cr_wp, r_cr_rp;
    logic [CrCntW-1:0] r_cr_cnt;
    logic              w_cr_empty, w_cr_full, w_cr_full_eff;
    idx_t              w_cr_head;
    logic              w_cr_rdy, w_cr_pop;

    idx_t              r_cd_mem [MaxCdPending];
    logic [CdPtrW-1:0] r_cd_wp, r_cd_rp;
    logic [CdCntW-1:0] r_cd_cnt;
    logic              w_cd_empty, w_cd_full;
    idx_t              w_cd_head;
    logic              w_cd_rdy, w_cd_push, w_cd_pop;

    function automatic logic [CrPtrW-1:0] f_cr_inc(input logic [CrPtrW-1:0] p);
        return (p == CrPtrW'(MaxOutstanding - 1)) ? '0 : p + CrPtrW'(1);
    endfunction

    function automatic logic [CdPtrW-1:0] f_cd_inc(input logic [CdPtrW-1:0] p);
        return (p == CdPtrW'(MaxCdPending - 1)) ? '0 : p + CdPtrW'(1);
    endfunction

    always_comb begin
        w_ac_req = '0;
        for (int i = 0; i < NumReq; i++) begin
            w_ac_req[i] = slv_snoop_req_i[i].ac_valid;
        end
    end

    ccu_snoop_port_arbiter_rr_arb #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_arb (
        .i_clk     (clk_i),
        .i_rst_n   (rst_ni),
        .i_req     (w_ac_req),
        .i_stall   (w_ac_stall),
        .i_hs      (w_ac_hs),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_vld (w_gnt_vld)
    );

    // A CR pop frees its owner slot in the same cycle, so a full FIFO still accepts an AC then.
    assign w_cr_full_eff = w_cr_full && !w_cr_pop;
    assign w_mst_ac_vld  = w_gnt_vld && !w_cr_full_eff;
    assign w_ac_hs       = w_mst_ac_vld && mst_snoop_resp_i.ac_ready;
    assign w_ac_stall    = w_mst_ac_vld && !mst_snoop_resp_i.ac_ready;

    assign w_cr_empty = (r_cr_cnt == '0);
    assign w_cr_full  = (r_cr_cnt == CrCntW'(MaxOutstanding));
    assign w_cr_head  = r_cr_mem[r_cr_rp];
    assign w_cr_rdy   = !w_cr_empty && slv_snoop_req_i[w_cr_head].cr_ready &&
                        !(mst_snoop_resp_i.cr_resp.data_transfer && w_cd_full);
    assign w_cr_pop   = mst_snoop_resp_i.cr_valid && w_cr_rdy;

    // Data-carrying CRs, including errored ones, always have a CD burst to drain.
    assign w_cd_push  = w_cr_pop && mst_snoop_resp_i.cr_resp.data_transfer;
    assign w_cd_empty = (r_cd_cnt == '0);
    assign w_cd_full  = (r_cd_cnt == CdCntW'(MaxCdPending));
    assign w_cd_head  = r_cd_mem[r_cd_rp];
    assign w_cd_rdy   = !w_cd_empty && slv_snoop_req_i[w_cd_head].cd_ready;
    assign w_cd_pop   = mst_snoop_resp_i.cd_valid && w_cd_rdy && mst_snoop_resp_i.cd.last;

    always_comb begin
        mst_snoop_req_o          = '0;
        mst_snoop_req_o.ac_valid = w_mst_ac_vld;
        mst_snoop_req_o.ac       = slv_snoop_req_i[w_gnt_idx].ac;
        mst_snoop_req_o.cr_ready = w_cr_rdy;
        mst_snoop_req_o.cd_ready = w_cd_rdy;
    end

    assign mst_domain_mask_o = slv_domain_mask_i[w_gnt_idx];
    assign mst_excl_load_o   = slv_excl_load_i[w_gnt_idx];
    assign mst_excl_store_o  = slv_excl_store_i[w_gnt_idx];

    always_comb begin
        slv_snoop_resp_o = '0;
        slv_excl_resp_o  = '0;
        for (int i = 0; i < NumReq; i++) begin
            slv_snoop_resp_o[i].ac_ready = w_gnt_vld && (w_gnt_idx == idx_t'(i)) &&
                                           mst_snoop_resp_i.ac_ready && !w_cr_full_eff;
            if (!w_cr_empty && (w_cr_head == idx_t'(i))) begin
                slv_snoop_resp_o[i].cr_valid = mst_snoop_resp_i.cr_valid;
                slv_snoop_resp_o[i].cr_resp  = mst_snoop_resp_i.cr_resp;
                slv_excl_resp_o[i]           = mst_excl_resp_i;
            end
            if (!w_cd_empty && (w_cd_head == idx_t'(i))) begin
                slv_snoop_resp_o[i].cd_valid = mst_snoop_resp_i.cd_valid;
                slv_snoop_resp_o[i].cd       = mst_snoop_resp_i.cd;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cr_wp  <= '0;
            r_cr_rp  <= '0;
            r_cr_cnt <= '0;
        end else begin
            if (w_ac_hs)  r_cr_wp <= f_cr_inc(r_cr_wp);
            if (w_cr_pop) r_cr_rp <= f_cr_inc(r_cr_rp);
            if (w_ac_hs && !w_cr_pop) begin
                r_cr_cnt <= r_cr_cnt + CrCntW'(1);
            end else if (!w_ac_hs && w_cr_pop) begin
                r_cr_cnt <= r_cr_cnt - CrCntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cd_wp  <= '0;
            r_cd_rp  <= '0;
            r_cd_cnt <= '0;
        end else begin
            if (w_cd_push) r_cd_wp <= f_cd_inc(r_cd_wp);
            if (w_cd_pop)  r_cd_rp <= f_cd_inc(r_cd_rp);
            if (w_cd_push && !w_cd_pop) begin
                r_cd_cnt <= r_cd_cnt + CdCntW'(1);
            end else if (!w_cd_push && w_cd_pop) begin
                r_cd_cnt <= r_cd_cnt - CdCntW'(1);
            end
        end
    end

    // Owner storage carries no reset; occupancy counters alone define validity.
    always_ff @(posedge clk_i) begin
        if (w_ac_hs)   r_cr_mem[r_cr_wp] <= w_gnt_idx;
        if (w_cd_push) r_cd_mem[r_cd_wp] <= w_cr_head;
    end

endmodule

// File: tb/tb_ccu_snoop_port_arbiter.sv
// Directed bench for ccu_snoop_port_arbiter: table-driven AC/CR vectors plus CR/CD/reset sequences.
module tb_ccu_snoop_port_arbiter;
    import ccu_snoop_port_arbiter_pkg::*;

    logic                  clk;
    logic                  rst_n;
    mst_snoop_req_t  [1:0] slv_req;
    mst_snoop_resp_t [1:0] slv_resp;
    domain_mask_t    [1:0] slv_dmask;
    logic            [1:0] slv_exl, slv_exs, slv_exr;
    mst_snoop_req_t        mst_req;
    mst_snoop_resp_t       mst_resp;
    domain_mask_t          mst_dmask;
    logic                  mst_exl, mst_exs, mst_exr;

    int n_chk;
    int n_fail;

    typedef struct packed {
        logic [1:0] req;
        logic       ac_rdy;
        logic       cr_vld;
        logic       e_ac_vld;
        int         e_gnt;
        logic [1:0] e_ac_rdy;
        logic [1:0] e_cr_vld;
        logic       e_cr_rdy;
    } vec_t;

    vec_t tbl [13];

    ccu_snoop_port_arbiter #(
        .NumReq         (2),
        .MaxOutstanding (4),
        .MaxCdPending   (2)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .slv_snoop_req_i   (slv_req),
        .slv_snoop_resp_o  (slv_resp),
        .slv_domain_mask_i (slv_dmask),
        .slv_excl_load_i   (slv_exl),
        .slv_excl_store_i  (slv_exs),
        .slv_excl_resp_o   (slv_exr),
        .mst_snoop_req_o   (mst_req),
        .mst_snoop_resp_i  (mst_resp),
        .mst_domain_mask_o (mst_dmask),
        .mst_excl_load_o   (mst_exl),
        .mst_excl_store_o  (mst_exs),
        .mst_excl_resp_i   (mst_exr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] ac_rdy_vec();
        return {slv_resp[1].ac_ready, slv_resp[0].ac_ready};
    endfunction

    function automatic logic [1:0] cr_vec();
        return {slv_resp[1].cr_valid, slv_resp[0].cr_valid};
    endfunction

    function automatic logic [1:0] cd_vec();
        return {slv_resp[1].cd_valid, slv_resp[0].cd_valid};
    endfunction

    task automatic issue_ac(input int i);
        slv_req[i].ac_valid = 1'b1;
        mst_resp.ac_ready   = 1'b1;
        @(negedge clk);
        chk($sformatf("issue_ac%0d_rdy", i), 32'(ac_rdy_vec()), 32'(2'b01 << i));
        tick();
        slv_req[i].ac_valid = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;

        tbl[0]  = '{2'b11, 1'b1, 1'b0, 1'b1,  0, 2'b01, 2'b00, 1'b0};
        tbl[1]  = '{2'b11, 1'b1, 1'b1, 1'b1,  1, 2'b10, 2'b01, 1'b1};
        tbl[2]  = '{2'b11, 1'b1, 1'b1, 1'b1,  0, 2'b01, 2'b10, 1'b1};
        tbl[3]  = '{2'b11, 1'b1, 1'b1, 1'b1,  1, 2'b10, 2'b01, 1'b1};
        tbl[4]  = '{2'b10, 1'b1, 1'b1, 1'b1,  1, 2'b10, 2'b10, 1'b1};
        tbl[5]  = '{2'b10, 1'b0, 1'b1, 1'b1,  1, 2'b00, 2'b10, 1'b1};
        tbl[6]  = '{2'b11, 1'b0, 1'b0, 1'b1,  1, 2'b00, 2'b00, 1'b0};
        tbl[7]  = '{2'b11, 1'b0, 1'b0, 1'b1,  1, 2'b00, 2'b00, 1'b0};
        tbl[8]  = '{2'b11, 1'b0, 1'b0, 1'b1,  1, 2'b00, 2'b00, 1'b0};
        tbl[9]  = '{2'b11, 1'b1, 1'b0, 1'b1,  1, 2'b10, 2'b00, 1'b0};
        tbl[10] = '{2'b01, 1'b1, 1'b1, 1'b1,  0, 2'b01, 2'b10, 1'b1};
        tbl[11] = '{2'b00, 1'b1, 1'b1, 1'b0, -1, 2'b00, 2'b01, 1'b1};
        tbl[12] = '{2'b00, 1'b1, 1'b1, 1'b0, -1, 2'b00, 2'b00, 1'b0};

        rst_n    = 1'b0;
        slv_req  = '0;
        mst_resp = '0;
        mst_exr  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            slv_req[i].ac.addr  = 16'hA000 + 16'(i);
            slv_req[i].cr_ready = 1'b1;
            slv_req[i].cd_ready = 1'b1;
        end
        slv_dmask[0] = 4'h3;
        slv_dmask[1] = 4'hC;
        slv_exl      = 2'b01;
        slv_exs      = 2'b10;

        // Reset state, with response valids pending from the crossbar
        mst_resp.cr_valid = 1'b1;
        mst_resp.cd_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ac_vld",  32'(mst_req.ac_valid), 32'd0);
        chk("rst_cr_rdy",  32'(mst_req.cr_ready), 32'd0);
        chk("rst_cd_rdy",  32'(mst_req.cd_ready), 32'd0);
        chk("rst_slv_cr",  32'(cr_vec()),         32'd0);
        chk("rst_slv_cd",  32'(cd_vec()),         32'd0);
        chk("rst_slv_rdy", 32'(ac_rdy_vec()),     32'd0);
        @(posedge clk);
        #1;
        rst_n             = 1'b1;
        mst_resp.cr_valid = 1'b0;
        mst_resp.cd_valid = 1'b0;

        // Arbitration, lock-until-handshake and in-order CR steering
        for (int r = 0; r < 13; r++) begin
            slv_req[0].ac_valid = tbl[r].req[0];
            slv_req[1].ac_valid = tbl[r].req[1];
            mst_resp.ac_ready   = tbl[r].ac_rdy;
            mst_resp.cr_valid   = tbl[r].cr_vld;
            mst_exr             = tbl[r].cr_vld;
            @(negedge clk);
            chk($sformatf("r%0d_ac_vld", r), 32'(mst_req.ac_valid), 32'(tbl[r].e_ac_vld));
            chk($sformatf("r%0d_ac_rdy", r), 32'(ac_rdy_vec()),     32'(tbl[r].e_ac_rdy));
            chk($sformatf("r%0d_cr_vld", r), 32'(cr_vec()),         32'(tbl[r].e_cr_vld));
            chk($sformatf("r%0d_excl",   r), 32'(slv_exr),          32'(tbl[r].e_cr_vld));
            chk($sformatf("r%0d_cr_rdy", r), 32'(mst_req.cr_ready), 32'(tbl[r].e_cr_rdy));
            if (tbl[r].e_gnt >= 0) begin
                chk($sformatf("r%0d_addr", r), 32'(mst_req.ac.addr), 32'(16'hA000 + 16'(tbl[r].e_gnt)));
                chk($sformatf("r%0d_mask", r), 32'(mst_dmask), 32'((tbl[r].e_gnt == 0) ? 4'h3 : 4'hC));
                chk($sformatf("r%0d_exl",  r), 32'(mst_exl),   32'(tbl[r].e_gnt == 0));
                chk($sformatf("r%0d_exs",  r), 32'(mst_exs),   32'(tbl[r].e_gnt == 1));
            end
            tick();
        end
        slv_req[0].ac_valid = 1'b0;
        slv_req[1].ac_valid = 1'b0;
        mst_resp.cr_valid   = 1'b0;
        mst_exr             = 1'b0;

        // Fill CR owner FIFO with owners 0,1,1,0; a fifth AC waits for a CR pop
        issue_ac(0);
        issue_ac(1);
        issue_ac(1);
        issue_ac(0);
        slv_req[1].ac_valid = 1'b1;
        mst_resp.ac_ready   = 1'b1;
        @(negedge clk);
        chk("full_ac_vld", 32'(mst_req.ac_valid),      32'd0);
        chk("full_ac_rdy", 32'(slv_resp[1].ac_ready),  32'd0);
        tick();
        mst_resp.cr_valid = 1'b1;
        mst_exr           = 1'b1;
        @(negedge clk);
        chk("full_pop_cr",     32'(cr_vec()),              32'(2'b01));
        chk("full_pop_excl",   32'(slv_exr),               32'(2'b01));
        chk("full_pop_ac_vld", 32'(mst_req.ac_valid),      32'd1);
        chk("full_pop_ac_rdy", 32'(slv_resp[1].ac_ready),  32'd1);
        tick();
        slv_req[1].ac_valid = 1'b0;
        begin
            int   own [4];
            logic exr [4];
            own = '{1, 1, 0, 1};
            exr = '{1'b0, 1'b1, 1'b1, 1'b0};
            for (int k = 0; k < 4; k++) begin
                mst_exr = exr[k];
                @(negedge clk);
                chk($sformatf("crseq%0d_vld",  k), 32'(cr_vec()), 32'(2'b01 << own[k]));
                chk($sformatf("crseq%0d_excl", k), 32'(slv_exr),  32'(exr[k] ? (2'b01 << own[k]) : 2'b00));
                tick();
            end
        end
        mst_resp.cr_valid = 1'b0;
        mst_exr           = 1'b0;

        // Owner-1 CR with data, then a 4-beat CD burst
        issue_ac(1);
        mst_resp.cr_valid              = 1'b1;
        mst_resp.cr_resp.data_transfer = 1'b1;
        @(negedge clk);
        chk("dt_cr_vld", 32'(cr_vec()),         32'(2'b10));
        chk("dt_cr_rdy", 32'(mst_req.cr_ready), 32'd1);
        tick();
        mst_resp.cr_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mst_resp.cd_valid   = 1'b1;
            mst_resp.cd.data    = 32'hD0 + 32'(b);
            mst_resp.cd.last    = (b == 3);
            @(negedge clk);
            chk($sformatf("cd%0d_vld",  b), 32'(cd_vec()),              32'(2'b10));
            chk($sformatf("cd%0d_rdy",  b), 32'(mst_req.cd_ready),      32'd1);
            chk($sformatf("cd%0d_data", b), 32'(slv_resp[1].cd.data),   32'hD0 + 32'(b));
            tick();
        end

        // CD raised ahead of its CR is held off until the CR handshake
        mst_resp.cd.data = 32'hE0;
        mst_resp.cd.last = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("early_cd%0d_rdy", c), 32'(mst_req.cd_ready), 32'd0);
            chk($sformatf("early_cd%0d_vld", c), 32'(cd_vec()),         32'd0);
            tick();
        end
        issue_ac(0);
        mst_resp.cr_valid = 1'b1;
        @(negedge clk);
        chk("early_cr_vld",    32'(cr_vec()),         32'(2'b01));
        chk("early_cr_cd_rdy", 32'(mst_req.cd_ready), 32'd0);
        tick();
        mst_resp.cr_valid = 1'b0;
        @(negedge clk);
        chk("early_b0_vld", 32'(cd_vec()),            32'(2'b01));
        chk("early_b0_rdy", 32'(mst_req.cd_ready),    32'd1);
        chk("early_b0_dat", 32'(slv_resp[0].cd.data), 32'hE0);
        tick();
        mst_resp.cd.data = 32'hE1;
        mst_resp.cd.last = 1'b1;
        @(negedge clk);
        chk("early_b1_vld", 32'(cd_vec()), 32'(2'b01));
        tick();
        mst_resp.cd_valid = 1'b0;

        // CD owner FIFO full back-pressures data CRs; CD last-pop with CR push
        issue_ac(0);
        issue_ac(1);
        issue_ac(0);
        mst_resp.cr_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("cdfill%0d_rdy", k), 32'(mst_req.cr_ready), 32'd1);
            tick();
        end
        @(negedge clk);
        chk("cdfull_cr_rdy", 32'(mst_req.cr_ready), 32'd0);
        chk("cdfull_cr_vld", 32'(cr_vec()),         32'(2'b01));
        tick();
        mst_resp.cr_valid = 1'b0;
        mst_resp.cd_valid = 1'b1;
        mst_resp.cd.data  = 32'hF0;
        mst_resp.cd.last  = 1'b1;
        @(negedge clk);
        chk("cdfull_pop_vld", 32'(cd_vec()), 32'(2'b01));
        tick();
        mst_resp.cr_valid = 1'b1;
        mst_resp.cd.data  = 32'hF1;
        @(negedge clk);
        chk("simul_cr_rdy", 32'(mst_req.cr_ready), 32'd1);
        chk("simul_cd_vld", 32'(cd_vec()),         32'(2'b10));
        chk("simul_cd_rdy", 32'(mst_req.cd_ready), 32'd1);
        tick();
        mst_resp.cr_valid = 1'b0;
        mst_resp.cd.data  = 32'hF2;
        @(negedge clk);
        chk("simul_tail_vld", 32'(cd_vec()), 32'(2'b01));
        tick();
        mst_resp.cd_valid              = 1'b0;
        mst_resp.cr_resp.data_transfer = 1'b0;

        // Reset with two ACs outstanding and the pointer away from 0
        issue_ac(1);
        issue_ac(0);
        mst_resp.cr_valid = 1'b1;
        @(negedge clk);
        chk("prerst_cr_vld", 32'(cr_vec()), 32'(2'b10));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_ac_vld", 32'(mst_req.ac_valid), 32'd0);
        chk("midrst_cr_rdy", 32'(mst_req.cr_ready), 32'd0);
        chk("midrst_cr_vld", 32'(cr_vec()),         32'd0);
        chk("midrst_cd_rdy", 32'(mst_req.cd_ready), 32'd0);
        rst_n               = 1'b1;
        slv_req[0].ac_valid = 1'b1;
        slv_req[1].ac_valid = 1'b1;
        mst_resp.ac_ready   = 1'b1;
        @(negedge clk);
        chk("postrst_addr",   32'(mst_req.ac.addr), 32'h0000A000);
        chk("postrst_ac_rdy", 32'(ac_rdy_vec()),    32'(2'b01));
        chk("postrst_cr_vld", 32'(cr_vec()),        32'd0);
        tick();
        slv_req[0].ac_valid = 1'b0;
        slv_req[1].ac_valid = 1'b0;
        mst_resp.cr_valid   = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
